sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single SRAM controller (32-bit data, 4-bit byte mask, `WREN`/`RDEN`/`ACK` handshake) between two requesters. The requesters are the instruction-fetch port and the load/store unit's SRAM path. The block latches one request at a time, drives the controller until it acknowledges or a watchdog expires, then returns data and a one-cycle ack to the granted requester. It sits between the core-side memory ports and `sram_IS61WV25616_controller_32b_3lr`.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: maximum cycles in BUSY without `i_sram_ack` before an error response. Legal range 1..1023.

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_if_req`  in  1  fetch request; held until `o_if_ack`.
- `i_if_addr`  in  32  fetch byte address. Fetch is read-only with mask 4'b1111.
- `o_if_rdata`  out  32  fetch read data, valid with `o_if_ack`.
- `o_if_ack`  out  1  one-cycle completion pulse.
- `o_if_err`  out  1  timeout flag, valid with `o_if_ack`.
- `i_ls_req`  in  1  load/store request; held until `o_ls_ack`.
- `i_ls_addr`  in  32  load/store byte address.
- `i_ls_wdata`  in  32  store data.
- `i_ls_bmask`  in  4  byte mask.
- `i_ls_wren`  in  1  1 = write, 0 = read.
- `o_ls_rdata`  out  32  load data, valid with `o_ls_ack`.
- `o_ls_ack`  out  1  one-cycle completion pulse.
- `o_ls_err`  out  1  timeout flag, valid with `o_ls_ack`.
- `o_sram_addr`, `o_sram_wdata`  out  32  drive the controller's `i_ADDR` and `i_WDATA`.
- `o_sram_bmask`  out  4  drives the controller's `i_BMASK`.
- `o_sram_wren`, `o_sram_rden`  out  1  drive the controller's `i_WREN` and `i_RDEN`; never both 1.
- `i_sram_rdata`  in  32  from the controller's `o_RDATA`.
- `i_sram_ack`  in  1  from the controller's `o_ACK`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:**
  - If any request is high, pick a winner and latch its addr, wdata, bmask, wren and id.
  - Go to BUSY and clear the watchdog counter.
  - No request: stay in IDLE.
- **BUSY:**
  - Hold the latched request on the `o_sram_*` outputs.
  - Assert `o_sram_wren` if wren is 1, otherwise assert `o_sram_rden`.
  - Requester input changes are ignored.
  - When `i_sram_ack` = 1: capture `i_sram_rdata` (0 for writes), set err = 0, go to RESP.
  - When the counter reaches `TIMEOUT_CYC` with no ack: set captured data = 0, err = 1, go to RESP.
  - Ack and timeout in the same cycle: ack wins, err = 0.
- **RESP:**
  - Enables are 0.
  - The granted requester's `o_*_ack` = 1 for exactly this cycle, with its rdata and err driven.
  - Next state is IDLE.
- The non-granted requester's ack, err and rdata stay 0.
- A requester that keeps `req` high in the cycle after its ack makes a new request.
- Arbitration: fixed priority, LSU over fetch. See Configuration for the alternative.
- Watchdog counter width is `$clog2(TIMEOUT_CYC+1)`. It saturates and never wraps.

## Timing
- Reset (`i_rst` = 1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: acks, errs, rdata, `o_sram_*`, enables.
  - Latched request fields and the round-robin pointer are cleared.
- Reset asserted mid-BUSY drops the enables on the next edge. The pending request is discarded and no ack is issued.
- Latency:
  - Request sampled in IDLE at edge N.
  - Enables asserted from cycle N+1.
  - Ack sampled at edge M puts RESP in cycle M+1.
  - IDLE in cycle M+2.
  - Minimum is request-to-ack of 2 cycles, when `i_sram_ack` arrives in the first BUSY cycle.
- Timeout response: RESP occurs `TIMEOUT_CYC`+1 cycles after entering BUSY.
- Throughput: one transaction per 3 cycles at best, because IDLE always spends one cycle between grants.
- Both requests high in the same IDLE cycle: resolved by the policy. The loser stays pending and its inputs are not latched.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant pointer is updated at each grant.
  - On a simultaneous request, the requester not granted last time wins.
  - The pointer resets to "fetch", so the first tie goes to the LSU.
- `SRAM_ARB_RR_EN` undefined: fixed priority, LSU wins every tie. No pointer flop exists.

## Structure
- Package `sram_arb_pkg`:
  - `arb_state_e` {IDLE, BUSY, RESP}.
  - `arb_id_e` {ID_IF, ID_LS}.
  - Struct `arb_req_t` {addr, wdata, bmask, wren}.
  - `TIMEOUT_CYC_DEF = 255`.
- Sub-module `sram_arb_pick`:
  - Combinational winner select from the two reqs and the last-grant pointer.
  - Contains the `SRAM_ARB_RR_EN` conditional.
- FSM, latches and watchdog live in `sram_arbiter`.

## Test plan
- Single LSU store of addr 0x2004, wdata 0xDEADBEEF, bmask 4'b1111; controller acks 3 cycles later. Expect `o_sram_wren` = 1 for those cycles, one `o_ls_ack` with err = 0, and `o_if_ack` stays 0.
- Fetch read of 0x2000; controller returns 0x00500093 with ack in the first BUSY cycle. Expect `o_if_ack` 2 cycles after the request, with rdata 0x00500093.
- Both reqs high continuously for 4 transactions. Fixed build: LSU, LSU, LSU, LSU. With `SRAM_ARB_RR_EN`: LSU, IF, LSU, IF.
- `TIMEOUT_CYC` = 8, controller never acks. Expect `o_ls_ack` = 1, err = 1, rdata = 0 in cycle 9 after BUSY entry, enables 0 in RESP, and a following fetch served normally.
- `i_rst` pulsed in the second BUSY cycle. Expect enables 0 next cycle, no ack to either requester, and a new request served from IDLE.
- Requester changes addr and wdata while in BUSY. Expect `o_sram_addr` and `o_sram_wdata` to hold the values latched at grant.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and constants for the two-port SRAM arbiter:
//                FSM state encoding, requester ids, latched request record
//                and the fetch request builder.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

    // Default watchdog limit in BUSY cycles
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    // Fetch accesses are always full-word reads
    localparam logic [3:0]  c_fetch_bmask   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ID_IF = 1'b0,
        ID_LS = 1'b1
    } arb_id_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic        wren;
    } arb_req_t;

    // Fetch is read-only: no write data, all byte lanes enabled
    function automatic arb_req_t fetch_req(input logic [31:0] addr);
        arb_req_t r;
        r.addr  = addr;
        r.wdata = '0;
        r.bmask = c_fetch_bmask;
        r.wren  = 1'b0;
        return r;
    endfunction

    // Load/store request as presented by the LSU
    function automatic arb_req_t ls_req(input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  bmask,
                                        input logic        wren);
        arb_req_t r;
        r.addr  = addr;
        r.wdata = wdata;
        r.bmask = bmask;
        r.wren  = wren;
        return r;
    endfunction

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pick
//  Description : Combinational winner select between the fetch port and the
//                load/store port. Default build: fixed priority, LSU wins
//                every tie. With SRAM_ARB_RR_EN defined: round-robin, the
//                requester not granted last time wins a tie.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic i_if_req,
    input  logic i_ls_req,
`ifdef SRAM_ARB_RR_EN
    input  logic i_last_grant,      // 0 = fetch, 1 = LSU granted last
`endif
    output logic o_grant,
    output logic o_winner           // 0 = fetch, 1 = LSU
);

    // Winner select; a lone requester always wins, only ties use the policy
    always_comb begin
        o_grant  = i_if_req | i_ls_req;
        o_winner = i_ls_req ? ID_LS : ID_IF;
`ifdef SRAM_ARB_RR_EN
        if (i_if_req && i_ls_req) begin
            o_winner = (i_last_grant == ID_IF) ? ID_LS : ID_IF;
        end
`endif
    end

endmodule : sram_arb_pick
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Shares one SRAM controller (WREN/RDEN/ACK handshake) between
//                the instruction-fetch port and the LSU. One request is
//                latched at a time and held on the controller until it acks
//                or a saturating watchdog expires; the granted requester then
//                gets a one-cycle ack with data and error flag.
//                Optional macro SRAM_ARB_RR_EN selects round-robin tie
//                breaking (default: fixed priority, LSU first).
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF   // legal 1..1023
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    // fetch port
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ack,
    output logic        o_if_err,
    // load/store port
    input  logic        i_ls_req,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_bmask,
    input  logic        i_ls_wren,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_ack,
    output logic        o_ls_err,
    // SRAM controller side
    output logic [31:0] o_sram_addr,
    output logic [31:0] o_sram_wdata,
    output logic [3:0]  o_sram_bmask,
    output logic        o_sram_wren,
    output logic        o_sram_rden,
    input  logic [31:0] i_sram_rdata,
    input  logic        i_sram_ack
);

    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    arb_state_e       state_q, state_d;
    arb_req_t         req_q,   req_d;
    arb_id_e          id_q,    id_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q,   err_d;

    logic             w_grant;
    logic             w_winner;

`ifdef SRAM_ARB_RR_EN
    logic             last_q, last_d;
`endif

    // ------------------------------------------------------------------
    // Winner select
    // ------------------------------------------------------------------
    sram_arb_pick u_pick (
        .i_if_req     (i_if_req),
        .i_ls_req     (i_ls_req),
`ifdef SRAM_ARB_RR_EN
        .i_last_grant (last_q),
`endif
        .o_grant      (w_grant),
        .o_winner     (w_winner)
    );

    // State, latched request, watchdog and response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            id_q    <= ID_IF;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Last-grant pointer; resets to fetch so the first tie goes to the LSU
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= ID_IF;
        end else begin
            last_q <= last_d;
        end
    end

    // Pointer follows every grant taken in IDLE
    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && w_grant) begin
            last_d = w_winner;
        end
    end
`endif

    // Next-state logic: grant in IDLE, wait for ack or watchdog in BUSY
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (w_grant) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    if (w_winner == ID_LS) begin
                        id_d  = ID_LS;
                        req_d = ls_req(i_ls_addr, i_ls_wdata, i_ls_bmask, i_ls_wren);
                    end else begin
                        id_d  = ID_IF;
                        req_d = fetch_req(i_if_addr);
                    end
                end
            end

            BUSY: begin
                // Ack is checked first so it wins over a same-cycle timeout
                if (i_sram_ack) begin
                    state_d = RESP;
                    rdata_d = req_q.wren ? 32'd0 : i_sram_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == c_cnt_max) begin
                    state_d = RESP;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    // Saturating: the compare above stops it at the limit
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: latched request on the SRAM bus, enables only in BUSY,
    // ack/data/err only to the granted requester in RESP
    always_comb begin
        o_sram_addr  = req_q.addr;
        o_sram_wdata = req_q.wdata;
        o_sram_bmask = req_q.bmask;
        o_sram_wren  = 1'b0;
        o_sram_rden  = 1'b0;
        o_if_ack     = 1'b0;
        o_if_err     = 1'b0;
        o_if_rdata   = 32'd0;
        o_ls_ack     = 1'b0;
        o_ls_err     = 1'b0;
        o_ls_rdata   = 32'd0;

        unique case (state_q)
            BUSY: begin
                o_sram_wren = req_q.wren;
                o_sram_rden = ~req_q.wren;
            end
            RESP: begin
                if (id_q == ID_LS) begin
                    o_ls_ack   = 1'b1;
                    o_ls_err   = err_q;
                    o_ls_rdata = rdata_q;
                end else begin
                    o_if_ack   = 1'b1;
                    o_if_err   = err_q;
                    o_if_rdata = rdata_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Self-checking bench for sram_arbiter. A reference model
//                predicts grant order, controller-side request fields and
//                the response of every transaction; a controller model and a
//                response monitor check the DUT against those predictions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int TMO   = 8;
    localparam int NEVER = 100000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic        wren;
        int          dly;        // BUSY cycles before the controller acks
        logic [31:0] ctl_rdata;  // data the controller returns with its ack
    } txn_t;

    typedef struct {
        logic        is_ls;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_rdata;
    logic        o_if_ack;
    logic        o_if_err;
    logic        i_ls_req;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_bmask;
    logic        i_ls_wren;
    logic [31:0] o_ls_rdata;
    logic        o_ls_ack;
    logic        o_ls_err;
    logic [31:0] o_sram_addr;
    logic [31:0] o_sram_wdata;
    logic [3:0]  o_sram_bmask;
    logic        o_sram_wren;
    logic        o_sram_rden;
    logic [31:0] i_sram_rdata;
    logic        i_sram_ack;

    txn_t  sram_q[$];
    resp_t resp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    ref_last_is_if = 1'b1;
    resp_t mon_r;

    always #5 i_clk = ~i_clk;

    sram_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .o_if_rdata   (o_if_rdata),
        .o_if_ack     (o_if_ack),
        .o_if_err     (o_if_err),
        .i_ls_req     (i_ls_req),
        .i_ls_addr    (i_ls_addr),
        .i_ls_wdata   (i_ls_wdata),
        .i_ls_bmask   (i_ls_bmask),
        .i_ls_wren    (i_ls_wren),
        .o_ls_rdata   (o_ls_rdata),
        .o_ls_ack     (o_ls_ack),
        .o_ls_err     (o_ls_err),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .o_sram_bmask (o_sram_bmask),
        .o_sram_wren  (o_sram_wren),
        .o_sram_rden  (o_sram_rden),
        .i_sram_rdata (i_sram_rdata),
        .i_sram_ack   (i_sram_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tie-break policy of the reference model
    function automatic bit ref_tie_goes_ls();
`ifdef SRAM_ARB_RR_EN
        return ref_last_is_if;
`else
        return 1'b1;
`endif
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.addr      = $urandom;
        t.wdata     = $urandom;
        t.bmask     = 4'($urandom);
        t.wren      = 1'($urandom);
        t.dly       = int'($urandom_range(0, 10));
        t.ctl_rdata = $urandom;
        return t;
    endfunction

    // Reference: record one grant, its controller-side view and its response
    task automatic expect_grant(input bit is_ls, input txn_t t);
        txn_t  s;
        resp_t r;
        s = t;
        if (!is_ls) begin
            s.wdata = 32'd0;
            s.bmask = 4'hF;
            s.wren  = 1'b0;
        end
        sram_q.push_back(s);
        r.is_ls = is_ls;
        r.err   = (t.dly > TMO);
        r.rdata = (r.err || s.wren) ? 32'd0 : t.ctl_rdata;
        resp_q.push_back(r);
        ref_last_is_if = !is_ls;
    endtask

    // One round: selected requesters raise req once and drop it on their ack
    task automatic do_round(input bit want_if, input bit want_ls,
                            input txn_t t_if, input txn_t t_ls, input bit mutate,
                            output int first_ack_cyc, output int busy_cyc);
        bit ls_first;
        bit cur_ls;
        int acks;
        int need;
        int cyc;
        acks = 0;
        cyc  = 0;
        need = int'(want_if) + int'(want_ls);
        ls_first = want_ls && (!want_if || ref_tie_goes_ls());
        if (ls_first) begin
            expect_grant(1'b1, t_ls);
            if (want_if) expect_grant(1'b0, t_if);
        end else begin
            expect_grant(1'b0, t_if);
            if (want_ls) expect_grant(1'b1, t_ls);
        end
        cur_ls     = ls_first;
        i_if_req   = want_if;
        i_if_addr  = t_if.addr;
        i_ls_req   = want_ls;
        i_ls_addr  = t_ls.addr;
        i_ls_wdata = t_ls.wdata;
        i_ls_bmask = t_ls.bmask;
        i_ls_wren  = t_ls.wren;
        first_ack_cyc = -1;
        busy_cyc      = 0;
        while (acks < need && cyc < 400) begin
            @(posedge i_clk); #1;
            cyc++;
            if (o_sram_rden || o_sram_wren) begin
                busy_cyc++;
                if (mutate) begin
                    if (cur_ls) begin
                        i_ls_addr  = $urandom;
                        i_ls_wdata = $urandom;
                    end else begin
                        i_if_addr = $urandom;
                    end
                end
            end
            if (o_if_ack) begin i_if_req = 1'b0; acks++; end
            if (o_ls_ack) begin i_ls_req = 1'b0; acks++; end
            if (o_if_ack || o_ls_ack) begin
                if (first_ack_cyc < 0) first_ack_cyc = cyc;
                cur_ls = !cur_ls;
            end
        end
        if (acks < need) check("round_acks", acks, need);
        i_if_req = 1'b0;
        i_ls_req = 1'b0;
        @(posedge i_clk); #1;
    endtask

    // Both requests held high across n transactions; returns grant order
    task automatic do_continuous(input int n, output logic [3:0] order);
        txn_t ti, tl;
        int   acks;
        int   cyc;
        bit   is_ls;
        ti = rand_txn(); ti.dly = int'($urandom_range(0, 3));
        tl = rand_txn(); tl.dly = int'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) begin
            is_ls = ref_tie_goes_ls();
            expect_grant(is_ls, is_ls ? tl : ti);
        end
        order      = '0;
        acks       = 0;
        cyc        = 0;
        i_if_req   = 1'b1;
        i_if_addr  = ti.addr;
        i_ls_req   = 1'b1;
        i_ls_addr  = tl.addr;
        i_ls_wdata = tl.wdata;
        i_ls_bmask = tl.bmask;
        i_ls_wren  = tl.wren;
        while (acks < n && cyc < 400) begin
            @(posedge i_clk); #1;
            cyc++;
            if (o_if_ack || o_ls_ack) begin
                order[acks] = o_ls_ack;
                acks++;
            end
        end
        if (acks < n) check("continuous_acks", acks, n);
        i_if_req = 1'b0;
        i_ls_req = 1'b0;
        @(posedge i_clk); #1;
    endtask

    // Reset pulsed in the second BUSY cycle of an LSU request
    task automatic do_reset_test();
        txn_t t;
        int   seen;
        int   g;
        t     = rand_txn();
        t.dly = NEVER;
        sram_q.push_back(t);            // reaches the controller, never answered
        seen  = 0;
        g     = 0;
        i_ls_req   = 1'b1;
        i_ls_addr  = t.addr;
        i_ls_wdata = t.wdata;
        i_ls_bmask = t.bmask;
        i_ls_wren  = t.wren;
        while (seen < 2 && g < 20) begin
            @(posedge i_clk); #1;
            g++;
            if (o_sram_rden || o_sram_wren) seen++;
        end
        check("rst_busy_reached", seen, 2);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst    = 1'b0;
        i_ls_req = 1'b0;
        ref_last_is_if = 1'b1;
        check("rst_enables_drop", 32'({o_sram_wren, o_sram_rden}), 32'd0);
        check("rst_sram_addr",    o_sram_addr, 32'd0);
        check("rst_acks",         32'({o_if_ack, o_ls_ack}), 32'd0);
        repeat (5) begin @(posedge i_clk); #1; end
    endtask

    // Controller model: answers after the predicted delay, checks bus fields
    initial begin : controller
        bit   active;
        int   bc;
        txn_t cur;
        active       = 1'b0;
        bc           = 0;
        cur          = rand_txn();
        i_sram_ack   = 1'b0;
        i_sram_rdata = 32'd0;
        forever begin
            @(posedge i_clk); #1;
            if (o_sram_wren || o_sram_rden) begin
                check("en_exclusive", 32'(o_sram_wren & o_sram_rden), 32'd0);
                if (!active) begin
                    active = 1'b1;
                    bc     = 0;
                    check("sram_txn_expected", 32'(sram_q.size() != 0), 32'd1);
                    if (sram_q.size() != 0) cur = sram_q.pop_front();
                    else cur.dly = NEVER;
                end
                check("sram_addr",  o_sram_addr, cur.addr);
                check("sram_bmask", 32'(o_sram_bmask), 32'(cur.bmask));
                check("sram_wren",  32'(o_sram_wren), 32'(cur.wren));
                if (cur.wren) check("sram_wdata", o_sram_wdata, cur.wdata);
                if (bc == cur.dly) begin
                    i_sram_ack   = 1'b1;
                    i_sram_rdata = cur.ctl_rdata;
                end else begin
                    i_sram_ack   = 1'b0;
                    i_sram_rdata = $urandom;
                end
                bc++;
            end else begin
                active       = 1'b0;
                i_sram_ack   = 1'b0;
                i_sram_rdata = $urandom;
            end
        end
    end

    // Response monitor: pops the scoreboard on every ack
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_if_ack || o_ls_ack) begin
                check("ack_onehot",   32'(o_if_ack & o_ls_ack), 32'd0);
                check("resp_enables", 32'({o_sram_wren, o_sram_rden}), 32'd0);
                check("ack_expected", 32'(resp_q.size() != 0), 32'd1);
                if (resp_q.size() != 0) begin
                    mon_r = resp_q.pop_front();
                    check("ack_id", 32'(o_ls_ack), 32'(mon_r.is_ls));
                    if (o_ls_ack) begin
                        check("ls_rdata",    o_ls_rdata, mon_r.rdata);
                        check("ls_err",      32'(o_ls_err), 32'(mon_r.err));
                        check("if_quiet",    o_if_rdata | 32'(o_if_err), 32'd0);
                    end else begin
                        check("if_rdata",    o_if_rdata, mon_r.rdata);
                        check("if_err",      32'(o_if_err), 32'(mon_r.err));
                        check("ls_quiet",    o_ls_rdata | 32'(o_ls_err), 32'd0);
                    end
                end
            end else begin
                check("idle_quiet", o_if_rdata | o_ls_rdata | {30'd0, o_if_err, o_ls_err}, 32'd0);
            end
        end
    end

    // Absolute time bound
    initial begin
        #3000000;
        $display("FAIL global_timeout: got no summary, required finish by %0t", $time);
        $fatal(1, "simulation time bound exceeded");
    end

    // Main stimulus
    initial begin
        txn_t       t, tn;
        int         fa, bc;
        logic [3:0] order;
        logic [3:0] exp_order;
        int         pat;

        i_rst      = 1'b1;
        i_if_req   = 1'b0;
        i_if_addr  = 32'd0;
        i_ls_req   = 1'b0;
        i_ls_addr  = 32'd0;
        i_ls_wdata = 32'd0;
        i_ls_bmask = 4'd0;
        i_ls_wren  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_sram_addr",  o_sram_addr, 32'd0);
        check("reset_sram_wdata", o_sram_wdata, 32'd0);
        check("reset_sram_bmask", 32'(o_sram_bmask), 32'd0);
        check("reset_enables",    32'({o_sram_wren, o_sram_rden}), 32'd0);
        check("reset_acks",       32'({o_if_ack, o_ls_ack, o_if_err, o_ls_err}), 32'd0);
        check("reset_rdata",      o_if_rdata | o_ls_rdata, 32'd0);
        i_rst = 1'b0;

        // Both requests held: tie policy over four transactions
`ifdef SRAM_ARB_RR_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        do_continuous(4, order);
        check("tie_order", 32'(order), 32'(exp_order));

        // LSU store, controller acks 3 cycles into BUSY
        tn = rand_txn();
        t  = rand_txn();
        t.addr = 32'h0000_2004; t.wdata = 32'hDEAD_BEEF; t.bmask = 4'b1111;
        t.wren = 1'b1; t.dly = 3;
        do_round(1'b0, 1'b1, tn, t, 1'b0, fa, bc);
        check("store_busy_cycles", bc, 4);

        // Fetch with ack in the first BUSY cycle
        t = rand_txn();
        t.addr = 32'h0000_2000; t.ctl_rdata = 32'h0050_0093; t.dly = 0;
        do_round(1'b1, 1'b0, t, tn, 1'b0, fa, bc);
        check("fetch_latency", fa, 2);

        // Watchdog expiry on an LSU access, then a normal fetch
        t = rand_txn();
        t.dly = NEVER;
        do_round(1'b0, 1'b1, tn, t, 1'b0, fa, bc);
        check("timeout_busy_cycles", bc, TMO + 1);
        t = rand_txn();
        t.dly = 1;
        do_round(1'b1, 1'b0, t, tn, 1'b0, fa, bc);
        check("after_timeout_fetch_latency", fa, 3);

        // Reset in mid-BUSY, then a fresh request
        do_reset_test();
        t = rand_txn();
        t.dly = 2;
        do_round(1'b0, 1'b1, tn, t, 1'b0, fa, bc);

        // Ack on the very cycle the watchdog expires: ack wins
        t = rand_txn();
        t.dly = TMO; t.wren = 1'b0;
        do_round(1'b0, 1'b1, tn, t, 1'b0, fa, bc);

        // Randomised rounds, with requester inputs churning during BUSY
        for (int r = 0; r < 40; r++) begin
            pat = int'($urandom_range(0, 2));
            do_round(pat != 1, pat != 0, rand_txn(), rand_txn(), 1'($urandom), fa, bc);
        end

        repeat (3) begin @(posedge i_clk); #1; end
        check("resp_q_drained", resp_q.size(), 0);
        check("sram_q_drained", sram_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire
